// File: rtl/alu_addsub_pipe.sv
// alu_addsub_pipe: two-stage pipelined WIDTH-bit adder/subtractor with
// valid/ready handshakes on both sides. S1 captures the request, S2 computes
// and registers the result and flags.
// Optional feature macro: ADDSUB_SAT_EN (signed saturation of the S2 result).
module alu_addsub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n
);

  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    logic             z;
    logic             n;
  } rsp_t;

  req_t s1_q, s1_d;
  logic s1_valid_q, s1_valid_d;
  rsp_t s2_q, s2_d;
  logic s2_valid_q, s2_valid_d;

  logic s1_free, s2_free;

  // Stage-advance conditions; in_ready depends on out_ready but never on in_valid
  assign s2_free  = !s2_valid_q | out_ready;
  assign s1_free  = !s1_valid_q | s2_free;
  assign in_ready = s1_free;

  // S1 next state: capture the request whenever the stage can move
  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (s1_free) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_d = '{a: opA, b: opB, sub: sub};
    end
  end

  logic [WIDTH-1:0] b_mux;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] res_fin;

  // S2 arithmetic: subtraction reuses the adder as opA + ~opB + 1
  always_comb begin
    b_mux = s1_q.sub ? ~s1_q.b : s1_q.b;
    sum   = {1'b0, s1_q.a} + {1'b0, b_mux} + {{WIDTH{1'b0}}, s1_q.sub};
    ovf   = (s1_q.a[MSB] == b_mux[MSB]) & (sum[MSB] != s1_q.a[MSB]);
`ifdef ADDSUB_SAT_EN
    // Clamp toward the sign of opA; overflow only happens when opA and B' agree
    if (ovf) res_fin = s1_q.a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else     res_fin = sum[WIDTH-1:0];
`else
    res_fin = sum[WIDTH-1:0];
`endif
  end

  // S2 next state: load from S1 when the output slot is free or draining
  always_comb begin
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d.res = res_fin;
        s2_d.c   = sum[WIDTH];
        s2_d.v   = ovf;
        s2_d.z   = (res_fin == '0);
        s2_d.n   = res_fin[MSB];
      end
    end
  end

  // Pipeline registers; async reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_q       <= s2_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_q.res;
  assign flag_c    = s2_q.c;
  assign flag_v    = s2_q.v;
  assign flag_z    = s2_q.z;
  assign flag_n    = s2_q.n;

endmodule
